cpu_ctrl_fsm: RTL
=================

CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 Parameter OPW, default 3: opcode width; SHALL be >= 3.
REQ-002 Parameter ROM_WAIT, default 0: extra wait cycles per ROM-access state.
REQ-003 Parameter RAM_WAIT, default 0: extra wait cycles per RAM-access state.
REQ-004 Parameter WCW, default 4: wait-counter width; ROM_WAIT and RAM_WAIT SHALL each be < 2^WCW.
REQ-005 Ports SHALL be:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  reset; asynchronous, active-high
- ins  in  OPW  opcode
- mem_rdy  in  1  memory ready
- resume  in  1  leave HALT
- write_r, read_r, PC_en, ac_ena, ram_ena, rom_ena, ram_write, ram_read, rom_read, ad_sel  out  1 each  control strobes and enables
- fetch  out  2  fetch phase
- halted  out  1  high in HALT
- illegal  out  1  one-cycle pulse on illegal opcode
- state_o  out  4  current state code

Function
REQ-006 The states SHALL be IDLE=F, F0=0, F1=1, HALT=2, O0=3, O1=4, LD=5, LDW=6, ST0=7, ST1=8, AL0=9, AL1=10, LM0=11, LM1=12; any other code SHALL go to IDLE.
REQ-007 Opcodes SHALL be NOP=0, LDO=1, LDA=2, STO=3, PRE=4, ADD=5, LDM=6, HLT=7; any ins with a nonzero bit above bit 2 is illegal.
REQ-008 Transitions SHALL be taken only on an advance cycle "adv":
- IDLE->F0, F0->F1.
- F1 decodes live ins: NOP or illegal->F0; HLT->HALT; PRE/ADD->AL0; LDM->LM0; else->O0.
- O0->O1.
- O1: LDO/LDA->LD, STO->ST0.
- LD->LDW->F0; ST0->ST1->F0; AL0->AL1->F0; LM0->LM1->F0.
REQ-009 In F1 on adv, ins[2:0] SHALL be latched into an instruction register ir; O1, LD and AL0 SHALL decode ir, not ins.
REQ-010 A state is a memory state when it asserts rom_read or ram_ena.
REQ-011 On entry to a memory state, the wait counter SHALL load RAM_WAIT if ram_ena is asserted, else ROM_WAIT.
REQ-012 In a memory state, adv SHALL be (count==0 && mem_rdy); the counter SHALL decrement by 1 per cycle while nonzero and SHALL not wrap.
REQ-013 In a non-memory state, adv SHALL be 1.
REQ-014 Outputs SHALL be combinational from state, ir and adv; unlisted outputs are 0; fetch defaults to 00:
- F0: rom_ena, rom_read, fetch=01.
- F1: rom_ena, rom_read, PC_en.
- O0: ac_ena, rom_ena, rom_read, fetch=10.
- O1: ac_ena, rom_ena, rom_read, PC_en, fetch=10.
- LD with ir=LDO: write_r, ac_ena, rom_ena, rom_read, ad_sel, fetch=01.
- LD with ir=LDA: write_r, ac_ena, ram_ena, ram_read, ad_sel, fetch=01.
- ST0: read_r. ST1: read_r, ram_ena, ram_write, ad_sel.
- AL0: read_r, ac_ena. AL1: read_r.
- LM0: write_r, ac_ena, rom_ena, rom_read.
- IDLE, HALT, LDW, LM1: all 0.
REQ-015 PC_en, write_r and ram_write SHALL be asserted only on the adv cycle of their state (exactly one pulse per instruction); the enables (ac_ena, ram_ena, rom_ena, ram_read, rom_read, read_r, ad_sel, fetch) SHALL be held for the whole state.
REQ-016 HALT SHALL hold until resume=1, then go to F0; resume SHALL be ignored outside HALT.
REQ-017 illegal SHALL pulse for one cycle on the F1 adv cycle that decodes an illegal opcode.
REQ-018 halted SHALL be 1 exactly when state==HALT; state_o SHALL equal the state code.

Reset
REQ-019 rst=1 SHALL immediately force state=IDLE, ir=0 and count=0, giving all outputs 0, fetch=00 and state_o=F, including mid-wait or mid-instruction.
REQ-020 The first rising edge after rst deasserts SHALL move IDLE->F0.

Structure
REQ-021 Package cpu_ctrl_pkg SHALL hold the opcode constants and the state enum/codes.
REQ-022 The wait counter SHALL be sub-module ctrl_wait_cnt (load, value, zero flag).

Verification
REQ-023 Reset release, ins=NOP, mem_rdy=1, waits 0 -> states F,0,1,0,1; PC_en pulses once per F1.
REQ-024 ins=LDA, RAM_WAIT=2 -> LD lasts 3 cycles with ram_ena/ram_read held; write_r high only in the 3rd cycle; ir stays 2 even if ins changes to 1 after F1.
REQ-025 ins=STO, mem_rdy low for 4 cycles in ST1 -> ST1 holds; ram_write pulses once, on the cycle mem_rdy rises.
REQ-026 ins=HLT -> HALT, halted=1 and outputs 0 for 10 cycles; resume=1 -> F0 next cycle.
REQ-027 OPW=4, ins=4'b1001 -> illegal pulses once in F1, next state F0, no data strobes.
REQ-028 rst asserted mid-ROM-wait in O1 -> state_o=F and all outputs 0 asynchronously; restart at F0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode and state encodings for the CPU control FSM, plus helpers that
// classify states by the memory they touch.
package cpu_ctrl_pkg;

   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_LDO = 3'd1;
   localparam logic [2:0] OP_LDA = 3'd2;
   localparam logic [2:0] OP_STO = 3'd3;
   localparam logic [2:0] OP_PRE = 3'd4;
   localparam logic [2:0] OP_ADD = 3'd5;
   localparam logic [2:0] OP_LDM = 3'd6;
   localparam logic [2:0] OP_HLT = 3'd7;

   typedef enum logic [3:0] {
      S_F0   = 4'd0,
      S_F1   = 4'd1,
      S_HALT = 4'd2,
      S_O0   = 4'd3,
      S_O1   = 4'd4,
      S_LD   = 4'd5,
      S_LDW  = 4'd6,
      S_ST0  = 4'd7,
      S_ST1  = 4'd8,
      S_AL0  = 4'd9,
      S_AL1  = 4'd10,
      S_LM0  = 4'd11,
      S_LM1  = 4'd12,
      S_IDLE = 4'hF
   } state_e;

   // RAM-side states; these take RAM_WAIT instead of ROM_WAIT on entry.
   function automatic logic is_ram_state(state_e s, logic [2:0] ir);
      return (s == S_ST1) || ((s == S_LD) && (ir == OP_LDA));
   endfunction

   function automatic logic is_mem_state(state_e s, logic [2:0] ir);
      return (s == S_F0) || (s == S_F1) || (s == S_O0) || (s == S_O1) ||
             (s == S_LM0) || (s == S_LD) || is_ram_state(s, ir);
   endfunction

endpackage

// File: rtl/ctrl_wait_cnt.sv
// Memory wait-state counter: loads on state entry, counts down to zero and
// sticks there.
module ctrl_wait_cnt #(
   parameter int WCW = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic [WCW-1:0] value,
   output logic           zero
);

   logic [WCW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load)
         count_d = value;
      else if (count_q != '0)
         count_d = count_q - WCW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control sequencer: fetch/decode/execute states with
// parameterised ROM/RAM wait states and a HALT/resume handshake.
module cpu_ctrl_fsm
   import cpu_ctrl_pkg::*;
#(
   parameter int OPW      = 3,
   parameter int ROM_WAIT = 0,
   parameter int RAM_WAIT = 0,
   parameter int WCW      = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [OPW-1:0] ins,
   input  logic           mem_rdy,
   input  logic           resume,
   output logic           write_r,
   output logic           read_r,
   output logic           PC_en,
   output logic           ac_ena,
   output logic           ram_ena,
   output logic           rom_ena,
   output logic           ram_write,
   output logic           ram_read,
   output logic           rom_read,
   output logic           ad_sel,
   output logic [1:0]     fetch,
   output logic           halted,
   output logic           illegal,
   output logic [3:0]     state_o
);

   state_e         state_q, state_d;
   logic [2:0]     ir_q, ir_d;
   logic           adv, mem_state, illegal_op;
   logic           cnt_zero, cnt_load;
   logic [WCW-1:0] cnt_value;
   logic           pc_req, wr_req, ramw_req;

   assign illegal_op = (ins >> 3) != '0;

   // Enables are held for the whole state; the *_req pulses are gated by adv.
   always_comb begin
      read_r = 1'b0; ac_ena = 1'b0; ram_ena = 1'b0; rom_ena = 1'b0;
      ram_read = 1'b0; rom_read = 1'b0; ad_sel = 1'b0; fetch = 2'b00;
      pc_req = 1'b0; wr_req = 1'b0; ramw_req = 1'b0;
      case (state_q)
         S_F0:  begin rom_ena = 1'b1; rom_read = 1'b1; fetch = 2'b01; end
         S_F1:  begin rom_ena = 1'b1; rom_read = 1'b1; pc_req = 1'b1; end
         S_O0:  begin ac_ena = 1'b1; rom_ena = 1'b1; rom_read = 1'b1; fetch = 2'b10; end
         S_O1:  begin
            ac_ena = 1'b1; rom_ena = 1'b1; rom_read = 1'b1; pc_req = 1'b1; fetch = 2'b10;
         end
         S_LD:  begin
            if (ir_q == OP_LDO) begin
               wr_req = 1'b1; ac_ena = 1'b1; rom_ena = 1'b1; rom_read = 1'b1;
               ad_sel = 1'b1; fetch = 2'b01;
            end else if (ir_q == OP_LDA) begin
               wr_req = 1'b1; ac_ena = 1'b1; ram_ena = 1'b1; ram_read = 1'b1;
               ad_sel = 1'b1; fetch = 2'b01;
            end
         end
         S_ST0: read_r = 1'b1;
         S_ST1: begin read_r = 1'b1; ram_ena = 1'b1; ramw_req = 1'b1; ad_sel = 1'b1; end
         S_AL0: begin read_r = 1'b1; ac_ena = 1'b1; end
         S_AL1: read_r = 1'b1;
         S_LM0: begin wr_req = 1'b1; ac_ena = 1'b1; rom_ena = 1'b1; rom_read = 1'b1; end
         default: ;
      endcase
   end

   assign mem_state = rom_read | ram_ena;
   assign adv       = mem_state ? (cnt_zero & mem_rdy) : 1'b1;
   assign PC_en     = pc_req & adv;
   assign write_r   = wr_req & adv;
   assign ram_write = ramw_req & adv;

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      illegal = 1'b0;
      if (adv) begin
         case (state_q)
            S_IDLE: state_d = S_F0;
            S_F0:   state_d = S_F1;
            S_F1: begin
               ir_d = ins[2:0];
               if (illegal_op) begin
                  illegal = 1'b1;
                  state_d = S_F0;
               end else begin
                  case (ins[2:0])
                     OP_NOP:         state_d = S_F0;
                     OP_HLT:         state_d = S_HALT;
                     OP_PRE, OP_ADD: state_d = S_AL0;
                     OP_LDM:         state_d = S_LM0;
                     default:        state_d = S_O0;
                  endcase
               end
            end
            S_HALT: if (resume) state_d = S_F0;
            S_O0:   state_d = S_O1;
            S_O1:   state_d = (ir_q == OP_STO) ? S_ST0 : S_LD;
            S_LD:   state_d = S_LDW;
            S_LDW:  state_d = S_F0;
            S_ST0:  state_d = S_ST1;
            S_ST1:  state_d = S_F0;
            S_AL0:  state_d = S_AL1;
            S_AL1:  state_d = S_F0;
            S_LM0:  state_d = S_LM1;
            S_LM1:  state_d = S_F0;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Every advance out of a memory state changes state, so adv alone marks entry.
   assign cnt_load  = adv & is_mem_state(state_d, ir_d);
   assign cnt_value = is_ram_state(state_d, ir_d) ? WCW'(RAM_WAIT) : WCW'(ROM_WAIT);

   ctrl_wait_cnt #(.WCW(WCW)) u_wait_cnt (
      .clk   (clk),
      .rst   (rst),
      .load  (cnt_load),
      .value (cnt_value),
      .zero  (cnt_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   assign halted  = (state_q == S_HALT);
   assign state_o = state_q;

endmodule
